// File: rtl/psg_write_arbiter.sv
// Two-requester round-robin arbiter that serialises register writes onto a PSG-style
// multiplexed address/data bus: an address cycle (phase 1) followed by a data cycle (phase 0).
module psg_write_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a_valid,
  input  logic [3:0] req_a_addr,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [3:0] req_b_addr,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic [7:0] bus_data,
  output logic       bus_phase,
  output logic       wr_done,
  output logic       busy
);

  typedef enum logic {
    PhaseData = 1'b0,
    PhaseAddr = 1'b1
  } phase_e;

  localparam logic [7:0] ParkAddr = 8'h0F;
  localparam logic [7:0] IdleData = 8'h00;

  phase_e     phase_q;
  logic [7:0] bus_data_q;
  logic       wr_done_q;
  logic       busy_q;
  logic [7:0] wdata_q;
  logic       last_a_q;

  logic       grant_a;
  logic       grant_b;
  logic       handshake;
  logic [3:0] sel_addr;
  logic [7:0] sel_data;

  // Grants only in data-phase cycles, so the following edge can launch the address byte.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && (phase_q == PhaseData)) begin
      if (req_a_valid && req_b_valid) begin
        grant_a = !last_a_q;
        grant_b = last_a_q;
      end else begin
        grant_a = req_a_valid;
        grant_b = req_b_valid;
      end
    end
  end

  assign handshake = grant_a | grant_b;
  assign sel_addr  = grant_a ? req_a_addr : req_b_addr;
  assign sel_data  = grant_a ? req_a_data : req_b_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= PhaseData;
      bus_data_q <= IdleData;
      wr_done_q  <= 1'b0;
      busy_q     <= 1'b0;
      wdata_q    <= 8'h00;
      last_a_q   <= 1'b0;
    end else begin
      unique case (phase_q)
        PhaseData: begin
          phase_q    <= PhaseAddr;
          bus_data_q <= handshake ? {4'h0, sel_addr} : ParkAddr;
          wr_done_q  <= 1'b0;
          busy_q     <= handshake;
          if (handshake) begin
            wdata_q  <= sel_data;
            last_a_q <= grant_a;
          end
        end
        PhaseAddr: begin
          // busy_q here marks a write whose address byte is on the bus this cycle.
          phase_q    <= PhaseData;
          bus_data_q <= busy_q ? wdata_q : IdleData;
          wr_done_q  <= busy_q;
        end
        default: phase_q <= PhaseData;
      endcase
    end
  end

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;
  assign bus_data    = bus_data_q;
  assign bus_phase   = (phase_q == PhaseAddr);
  assign wr_done     = wr_done_q;
  assign busy        = busy_q;

endmodule

// File: doc/psg_write_arbiter.md
PSG_WRITE_ARBITER -- requirements
Module: psg_write_arbiter

Interface
REQ-001: clk  input  1  single clock; all state changes on its rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: req_a_valid  input  1  requester A has a register write pending.
REQ-004: req_a_addr  input  4  requester A target register number (0-15).
REQ-005: req_a_data  input  8  requester A write value.
REQ-006: req_a_ready  output  1  grant to A; the write transfers when req_a_valid and req_a_ready are both high in the same cycle.
REQ-007: req_b_valid, req_b_addr, req_b_data, req_b_ready SHALL mirror REQ-003..006 for requester B.
REQ-008: bus_data  output  8  registered byte driven into the PSG register-file data input.
REQ-009: bus_phase  output  1  1 = address cycle (target latches bus_data[3:0] as register number), 0 = data cycle (target writes bus_data to the latched register).
REQ-010: wr_done  output  1  one-cycle pulse during the data cycle of a granted write.
REQ-011: busy  output  1  high while a granted write has not yet completed its data cycle.

Function
REQ-012: bus_phase SHALL be a free-running toggle: 0 in the first cycle after reset, then inverting every cycle, so it stays in lockstep with the target's own latch toggle.
REQ-013: Grants SHALL be issued only in cycles with bus_phase=0; req_a_ready and req_b_ready SHALL be 0 in every bus_phase=1 cycle and during reset.
REQ-014: In a bus_phase=0 cycle, ready SHALL be combinational from the valids and the round-robin state. At most one ready is high per cycle.
REQ-015: Arbitration, only A valid: grant A. Only B valid: grant B. Both valid: grant the requester not granted most recently. Neither valid: no grant.
REQ-016: Round-robin state SHALL update only on a completed handshake.
REQ-017: A requester SHALL hold valid, addr and data stable until granted. The block SHALL capture addr and data on the handshake edge.
REQ-018: Edge ending a bus_phase=0 cycle: bus_data <= {4'h0, granted addr} if a handshake occurred, else 8'h0F (parking register 15, unmapped).
REQ-019: Edge ending a bus_phase=1 cycle: bus_data <= captured data if a write is in flight, else 8'h00.
REQ-020: Latency: handshake in cycle t -> address on bus_data in cycle t+1 -> data on bus_data plus wr_done=1 in cycle t+2.
REQ-021: Throughput: a new grant SHALL be possible in cycle t+2, concurrent with the previous write's data cycle. This gives one write per 2 cycles back-to-back with no bubbles.
REQ-022: busy SHALL be 1 in cycles t+1 and t+2 of each write, and 0 otherwise unless a new write was granted.
REQ-023: Idle bus SHALL alternate 0x0F (phase 1) and 0x00 (phase 0), so no mapped register is ever modified.
REQ-024: Addresses 14 and 15 SHALL be accepted and sequenced like any other address. This has no effect on the target.

Reset
REQ-025: While reset is high, on each edge: bus_phase <= 0, bus_data <= 8'h00, wr_done <= 0, busy <= 0, in-flight write discarded, round-robin last-grant <= B (A wins the first tie).
REQ-026: Reset asserted mid-write SHALL abort that write: no wr_done, and its data byte is never driven. A request still valid after reset SHALL be re-granted in the first post-reset cycle.
REQ-027: The first post-reset cycle drives bus_data=0x00 in a data cycle to latched register 0. This matches the target's reset value and is benign.

Verification
REQ-028: Reset, then no requests for 8 cycles -> bus_data 00,0F,00,0F,...; bus_phase 0,1,0,1; both ready 0; wr_done 0; busy 0.
REQ-029: A valid addr=8 data=0x1F in cycle 0 after reset -> req_a_ready=1 in cycle 0; cycle 1 bus_data=0x08, phase=1, busy=1; cycle 2 bus_data=0x1F, phase=0, wr_done=1; cycle 3 bus_data=0x0F.
REQ-030: A and B valid continuously, A addr 0/data 0x11 and B addr 2/data 0x22 -> grants A,B,A,B in cycles 0,2,4,6; bus_data 00,00,11,02,22,00,11,... from cycle 0; wr_done high in cycles 2,4,6.
REQ-031: B raises valid in a phase=1 cycle (cycle 1) -> req_b_ready=0 in cycle 1, =1 in cycle 2; address 0x0? appears cycle 3.
REQ-032: A granted in cycle 0 (addr 9, data 0x0A), reset high in cycle 1 -> cycle 2 bus_data=0x00, phase=0, wr_done=0, busy=0; A still valid -> re-granted in cycle 2 and completes in cycle 4.
